// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer.
// State encoding, the read-only ID word and default geometry live here.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_ACCESS   = 2'd2,
        ST_RESP_ERR = 2'd3
    } apb_state_e;

    localparam logic [31:0] REG_ID          = 32'hA9B0_0001;
    localparam int          DEF_ADDR_WIDTH  = 32;
    localparam int          DEF_DATA_WIDTH  = 32;
    localparam int          DEF_NUM_REGS    = 16;
    localparam int          DEF_WAIT_STATES = 1;

    // The first penable cycle is spent in SETUP, so ACCESS needs one fewer count.
    function automatic logic [3:0] wait_load(input int ws);
        return (ws > 0) ? 4'(ws - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// Byte-strobed register array: one write port, one read port.
// Index 0 is never stored; it reads back the fixed ID word.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic [IDX_W-1:0]        i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (i_wstrb[b]) begin
                    r_regs[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = (i_raddr == '0) ? DATA_WIDTH'(REG_ID) : r_regs[i_raddr];

endmodule

// File: rtl/apb_regfile_completer.sv
// APB completer in front of a small register file with programmable wait states.
//   state    | meaning
//   IDLE     | no transfer; waiting for a setup phase (psel=1, penable=0)
//   SETUP    | request captured; first access cycle in progress
//   ACCESS   | wait-state countdown; completes when the counter reaches 0
//   RESP_ERR | one-cycle error response after a protocol violation
module apb_regfile_completer
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int         IDX_W    = $clog2(NUM_REGS);
    localparam int         STRB_W   = DATA_WIDTH/8;
    localparam logic [3:0] CNT_LOAD = wait_load(WAIT_STATES);

    apb_state_e              r_state;
    apb_state_e              w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_strb;
    logic [3:0]              r_cnt;

    logic                    w_capture;
    logic                    w_abort;
    logic                    w_acc_err;
    logic                    w_we;
    logic [IDX_W-1:0]        w_idx;
    logic [DATA_WIDTH-1:0]   w_rdata;

    assign w_idx     = r_addr[IDX_W+1:2];
    assign w_acc_err = (r_addr[1:0] != 2'b00)
                    || (r_addr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(NUM_REGS))
                    || (r_write && (r_addr[ADDR_WIDTH-1:2] == '0));
    assign w_capture = ((r_state == ST_IDLE) || (r_state == ST_SETUP)) && psel && !penable;
    assign w_abort   = !psel || (paddr != r_addr) || (pwrite != r_write);

    // A violation seen in the would-be completion cycle still wins over completion.
    always_comb begin
        w_next  = r_state;
        pready  = 1'b0;
        pslverr = 1'b0;
        w_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (!psel)        w_next = ST_IDLE;
                else if (penable) w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_abort) begin
                    w_next = ST_RESP_ERR;
                end else if (r_cnt == 4'd0) begin
                    pready  = 1'b1;
                    pslverr = w_acc_err;
                    w_we    = r_write && !w_acc_err;
                    w_next  = ST_IDLE;
                end
            end
            ST_RESP_ERR: begin
                pready  = 1'b1;
                pslverr = 1'b1;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign prdata = (pready && !pslverr && !r_write) ? w_rdata : '0;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_strb  <= pstrb;
            end
            if ((r_state == ST_SETUP) && (w_next == ST_ACCESS)) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == ST_ACCESS) begin
                r_cnt <= (w_next == ST_ACCESS) ? r_cnt - 4'd1 : 4'd0;
            end
        end
    end

    apb_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk     (pclk),
        .rst     (preset),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (r_wdata),
        .i_wstrb (r_strb),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

endmodule
